// File: rtl/uart_bus_bridge_pkg.sv
// uart_bus_bridge_pkg: shared types and constants for the UART-to-bus debug
// bridge.
//   bridge_state_e : command FSM states
//   Cmd*/Resp*     : wire-protocol byte values
//   cnt_width()    : counter width helper for down-counters loaded with n-1
package uart_bus_bridge_pkg;

  typedef enum logic [2:0] {
    CMD      = 3'd0,
    ADDR     = 3'd1,
    WDATA    = 3'd2,
    BUS_REQ  = 3'd3,
    BUS_WAIT = 3'd4,
    RESP     = 3'd5
  } bridge_state_e;

  localparam logic [7:0] CmdWrite  = 8'h77;
  localparam logic [7:0] CmdRead   = 8'h72;
  localparam logic [7:0] RespAck   = 8'h06;
  localparam logic [7:0] RespNak   = 8'h15;
  localparam logic [3:0] HostBeAll = 4'hF;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bridge_serdes.sv
// uart_bridge_serdes: 8N1 UART receiver and transmitter for the debug bridge.
// Ports:
//   clk_i, rst_ni   : clock, async active-low reset
//   rx              : asynchronous serial input (idle high)
//   tx              : serial output (idle high)
//   rx_data/rx_valid: received byte, rx_valid is a 1-cycle pulse
//   rx_frame_err    : 1-cycle pulse when a stop bit is sampled low
//   tx_data/tx_valid/tx_ready : byte handshake into the transmitter
//   tx_idle         : transmitter has finished its last stop bit
// Parameter ClocksPerBaud (>= 4) sets the bit period in clk_i cycles.
module uart_bridge_serdes
  import uart_bus_bridge_pkg::*;
#(
  parameter int ClocksPerBaud = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_idle
);

  localparam int CntW = cnt_width(ClocksPerBaud);
  localparam logic [CntW-1:0] BaudLast = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(ClocksPerBaud / 2);

  localparam logic [1:0] RxIdle  = 2'd0;
  localparam logic [1:0] RxStart = 2'd1;
  localparam logic [1:0] RxData  = 2'd2;
  localparam logic [1:0] RxStop  = 2'd3;

  logic            rx_s1, rx_s2, rx_s3;
  logic [1:0]      rx_state;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;

  assign rx_data = rx_shift;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_s3        <= 1'b1;
      rx_state     <= RxIdle;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= rx;
      rx_s2        <= rx_s1;
      rx_s3        <= rx_s2;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_state == RxIdle) begin
        // Half-bit load puts every later sample near mid-bit.
        if (rx_s3 && !rx_s2) begin
          rx_cnt   <= BaudHalf;
          rx_state <= RxStart;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CntW'(1);
      end else begin
        rx_cnt <= BaudLast;
        case (rx_state)
          RxStart: begin
            // A start bit that is high again by mid-bit was a glitch.
            if (rx_s2) begin
              rx_state <= RxIdle;
            end else begin
              rx_state <= RxData;
              rx_bit   <= '0;
            end
          end
          RxData: begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RxStop;
          end
          default: begin
            rx_state <= RxIdle;
            if (rx_s2) rx_valid <= 1'b1;
            else       rx_frame_err <= 1'b1;
          end
        endcase
      end
    end
  end

  logic            tx_busy;
  logic [CntW-1:0] tx_cnt;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_shift;

  // Ready also in the last cycle of a stop bit so consecutive bytes leave
  // without an idle gap.
  assign tx_ready = !tx_busy || (tx_cnt == '0 && tx_bit == 4'd9);
  assign tx_idle  = !tx_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      tx       <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= BaudLast;
      tx_bit   <= '0;
      tx_shift <= {1'b1, tx_data};
      tx       <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CntW'(1);
      end else if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        tx_cnt   <= BaudLast;
        tx_bit   <= tx_bit + 4'd1;
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
      end
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART debug port that issues single word reads/writes on
// the system bus and reports status (and read data) back over UART.
// Ports:
//   clk_i, rst_ni           : clock, async active-low reset
//   uart_rx_i, uart_tx_o    : debug UART pins (idle high)
//   host_req_o/host_gnt_i   : bus request/grant
//   host_addr_o, host_we_o, host_be_o, host_wdata_o : request payload
//   host_rvalid_i, host_rdata_i, host_err_i         : bus response
//   busy_o                  : command FSM is away from CMD
// Build option: define UART_BUS_BRIDGE_TIMEOUT_EN to abandon a partial frame
// after TimeoutBauds idle bit periods; without it a partial frame waits
// forever.
//
// state    | meaning
// CMD      | waiting for a command byte
// ADDR     | collecting 4 address bytes
// WDATA    | collecting 4 write-data bytes
// BUS_REQ  | request on the bus, waiting for grant
// BUS_WAIT | granted, waiting for the response
// RESP     | sending status (and read data) back over UART
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int TimeoutBauds   = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  output logic        busy_o
);

  localparam int ClocksPerBaud = ClockFrequency / BaudRate;

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_err;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_idle;

  uart_bridge_serdes #(
    .ClocksPerBaud(ClocksPerBaud)
  ) u_serdes (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx          (uart_rx_i),
    .tx          (uart_tx_o),
    .rx_data     (rx_byte),
    .rx_valid    (rx_byte_valid),
    .rx_frame_err(rx_frame_err),
    .tx_data     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_idle     (tx_idle)
  );

  bridge_state_e state;
  logic [1:0]    byte_cnt;
  logic          is_write;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [2:0]    resp_cnt;
  logic [2:0]    resp_len;
  logic          timeout;
  logic          frame_abort;

  assign host_req_o   = (state == BUS_REQ);
  assign host_addr_o  = {addr_q, 2'b00};
  assign host_we_o    = is_write;
  assign host_be_o    = HostBeAll;
  assign host_wdata_o = wdata_q;
  assign busy_o       = (state != CMD);

  assign frame_abort = rx_frame_err || timeout;
  assign resp_len    = (!is_write && !err_q) ? 3'd5 : 3'd1;

  always_comb begin
    tx_valid = (state == RESP) && (resp_cnt < resp_len);
    case (resp_cnt)
      3'd1:    tx_byte = rdata_q[7:0];
      3'd2:    tx_byte = rdata_q[15:8];
      3'd3:    tx_byte = rdata_q[23:16];
      3'd4:    tx_byte = rdata_q[31:24];
      default: tx_byte = err_q ? RespNak : RespAck;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= CMD;
      byte_cnt <= '0;
      is_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      resp_cnt <= '0;
    end else begin
      case (state)
        CMD: begin
          if (rx_byte_valid) begin
            byte_cnt <= '0;
            if (rx_byte == CmdWrite) begin
              is_write <= 1'b1;
              state    <= ADDR;
            end else if (rx_byte == CmdRead) begin
              is_write <= 1'b0;
              state    <= ADDR;
            end
          end
        end
        ADDR: begin
          if (frame_abort) begin
            state <= CMD;
          end else if (rx_byte_valid) begin
            case (byte_cnt)
              2'd0: addr_q[7:2]   <= rx_byte[7:2];
              2'd1: addr_q[15:8]  <= rx_byte;
              2'd2: addr_q[23:16] <= rx_byte;
              2'd3: addr_q[31:24] <= rx_byte;
              default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= is_write ? WDATA : BUS_REQ;
          end
        end
        WDATA: begin
          if (frame_abort) begin
            state <= CMD;
          end else if (rx_byte_valid) begin
            wdata_q[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          if (host_gnt_i) state <= BUS_WAIT;
        end
        BUS_WAIT: begin
          if (host_rvalid_i) begin
            rdata_q  <= host_rdata_i;
            err_q    <= host_err_i;
            resp_cnt <= '0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (tx_valid && tx_ready) resp_cnt <= resp_cnt + 3'd1;
          // Leave only once the final stop bit has gone out.
          if (resp_cnt == resp_len && tx_idle) state <= CMD;
        end
        default: state <= CMD;
      endcase
    end
  end

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
  localparam int TickW = cnt_width(ClocksPerBaud);
  localparam int ToW   = cnt_width(TimeoutBauds + 1);

  logic [TickW-1:0] to_tick;
  logic [ToW-1:0]   to_left;
  logic             in_frame;

  assign in_frame = (state == ADDR) || (state == WDATA);
  assign timeout  = in_frame && (to_left == '0);

  // Bit periods since the last good byte; restarts on every byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_tick <= TickW'(ClocksPerBaud - 1);
      to_left <= ToW'(TimeoutBauds);
    end else if (!in_frame || rx_byte_valid) begin
      to_tick <= TickW'(ClocksPerBaud - 1);
      to_left <= ToW'(TimeoutBauds);
    end else if (to_tick == '0) begin
      to_tick <= TickW'(ClocksPerBaud - 1);
      if (to_left != '0) to_left <= to_left - ToW'(1);
    end else begin
      to_tick <= to_tick - TickW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
